sb_tx_serializer: RTL and testbench
===================================

Name: sb_tx_serializer

Overview:
- Sideband TX serializer, directly downstream of the sideband TX FIFO.
- Pops one 64-bit sideband packet per transaction, shifts it out LSB-first on the 1-bit sideband data lane, then forces the mandatory idle gap.
- Generates the enable for the forwarded sideband clock: the clock toggles only during packet bits.
- Runs on the sideband serial clock; one clock cycle equals one UI.

Parameters:
- PKT_W, 64, packet width in bits (UI per packet).
- GAP_UI, 32, idle UI driven low after each packet before the next fetch may start.

Ports:
- i_clk  input  1  sideband serial clock, one UI per cycle.
- i_rst_n  input  1  asynchronous active-low reset.
- i_enable  input  1  sideband TX enabled by link control; gates new fetches only.
- i_empty  input  1  FIFO registered empty flag.
- i_data  input  PKT_W  FIFO read data; valid the cycle after o_read_enable.
- o_read_enable  output  1  one-cycle FIFO pop strobe.
- o_txdata_sb  output  1  serial sideband data.
- o_clk_en  output  1  forwarded sideband clock gate enable.
- o_busy  output  1  high whenever state is not IDLE.
- o_pkt_done  output  1  one-cycle pulse on the last data UI of a packet.

Behaviour:
- Clock and reset: clock i_clk; reset i_rst_n, asynchronous, active-low.
- Reset values: state IDLE, shift register 0, counter 0, all outputs 0.
- Reset mid-packet aborts immediately: o_txdata_sb and o_clk_en go 0 asynchronously, and no further pops occur.
- States: IDLE, FETCH, LOAD, SHIFT, GAP.
- IDLE -> FETCH when i_enable=1 and i_empty=0; otherwise stay in IDLE.
- FETCH (1 cycle): o_read_enable=1 (combinational from state). Always -> LOAD.
- LOAD (1 cycle): i_data is valid. At the edge: shift register <= i_data, counter <= 0, -> SHIFT.
- SHIFT (PKT_W cycles):
  - o_txdata_sb = shift register bit 0; o_clk_en = 1.
  - Each edge: shift register >> 1 (zero fill), counter +1.
  - When counter = PKT_W-1: o_pkt_done=1, counter <= 0, -> GAP.
- GAP (GAP_UI cycles): o_txdata_sb=0, o_clk_en=0. When counter = GAP_UI-1:
  - -> FETCH if i_enable=1 and i_empty=0;
  - else -> IDLE.
- Outside SHIFT, o_txdata_sb=0 and o_clk_en=0. No glitches: both are derived from registered state and shift register only.
- Latency: FETCH at cycle T0 gives first data UI at T2 and last data UI at T2+PKT_W-1.
- Packet-to-packet spacing:
  - Back-to-back start-of-packet spacing is PKT_W+GAP_UI+2 cycles (98 at defaults).
  - Effective low gap is GAP_UI+2 UI.
- Empty handling: a pop is never issued while i_empty=1. The registered empty lag is harmless because successive pops are at least 98 cycles apart.
- i_enable deassert: an in-flight packet (LOAD/SHIFT/GAP) always completes, with no truncation. Only the next fetch is blocked. Deassert in FETCH has no effect; the pop already occurred.
- Counter is ceil(log2(max(PKT_W,GAP_UI))) bits wide (6 at defaults); it never wraps past its terminal value.
- o_busy = (state != IDLE).

Test Plan:
- FIFO holds 64'h0123_4567_89AB_CDEF, i_enable=1 -> one o_read_enable pulse. o_clk_en high for exactly 64 cycles starting 2 cycles after the pulse. o_txdata_sb sequence (LSB first) is 1,1,1,1,0,1,1,1... reassembling to 64'h0123_4567_89AB_CDEF. o_pkt_done pulses on UI 63, then 32 low UI.
- Two packets queued (64'hFFFF_FFFF_FFFF_FFFF, then 64'h0) -> second o_read_enable exactly 98 cycles after the first. Packet 1 is 64 ones and packet 2 is 64 zeros, both with o_clk_en high; 34 UI of o_clk_en=0 between them.
- i_empty=1 held for 200 cycles -> o_read_enable, o_clk_en, o_busy and o_txdata_sb all stay 0.
- i_enable dropped at SHIFT UI 10 with a second packet pending -> current packet completes all 64 UI. State returns to IDLE after the gap, with no second pop until i_enable=1.
- i_rst_n asserted at SHIFT UI 20 -> o_clk_en, o_txdata_sb and o_busy go 0 immediately. After release with the FIFO empty, no activity follows.
- i_enable=1 while i_empty toggles 1->0 during GAP -> the fetch occurs on the cycle after the gap's last UI, never earlier.

Source files
------------

// File: rtl/sb_tx_serializer.sv
// Sideband TX serializer: pops one packet from the TX FIFO, shifts it out LSB-first
// with a gated forwarded clock, then holds the mandatory idle gap before the next fetch.
module sb_tx_serializer #(
    parameter int PKT_W  = 64,
    parameter int GAP_UI = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_empty,
    input  logic [PKT_W-1:0] i_data,
    output logic             o_read_enable,
    output logic             o_txdata_sb,
    output logic             o_clk_en,
    output logic             o_busy,
    output logic             o_pkt_done
);

    localparam int CNT_W = $clog2((PKT_W > GAP_UI) ? PKT_W : GAP_UI);
    localparam logic [CNT_W-1:0] PKT_LAST = CNT_W'(PKT_W - 32'd1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_UI - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        SHIFT = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [PKT_W-1:0]   shift_r;
    logic [PKT_W-1:0]   shift_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;

    // State, shift register and UI counter; reset aborts any packet in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
            shift_r <= {PKT_W{1'b0}};
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            shift_r <= shift_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state logic: enable only gates the decision to start a new fetch.
    always_comb begin
        state_s = state_r;
        shift_s = shift_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (i_enable && !i_empty) begin
                    state_s = FETCH;
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                state_s = LOAD;
            end
            LOAD: begin
                shift_s = i_data;
                cnt_s   = CNT_ZERO;
                state_s = SHIFT;
            end
            SHIFT: begin
                shift_s = {1'b0, shift_r[PKT_W-1:1]};
                if (cnt_r == PKT_LAST) begin
                    cnt_s   = CNT_ZERO;
                    state_s = GAP;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            GAP: begin
                if (cnt_r == GAP_LAST) begin
                    cnt_s = CNT_ZERO;
                    if (i_enable && !i_empty) begin
                        state_s = FETCH;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                shift_s = {PKT_W{1'b0}};
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Lane and clock gate decode only from registered state, so they cannot glitch.
    assign o_read_enable = (state_r == FETCH);
    assign o_clk_en      = (state_r == SHIFT);
    assign o_txdata_sb   = (state_r == SHIFT) & shift_r[0];
    assign o_busy        = (state_r != IDLE);
    assign o_pkt_done    = (state_r == SHIFT) & (cnt_r == PKT_LAST);

endmodule

// File: tb/tb_sb_tx_serializer.sv
// Scoreboard bench for sb_tx_serializer: a FIFO model feeds packets, a monitor
// reassembles the serial lane and checks timing rules against expected packets.
module tb_sb_tx_serializer;

    localparam int PKT_W    = 64;
    localparam int GAP_UI   = 32;
    localparam int SPACING  = PKT_W + GAP_UI + 2;
    localparam int LOW_RUN  = GAP_UI + 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        empty;
    logic [63:0] data;
    logic        rd;
    logic        txd;
    logic        clk_en;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    // FIFO model: stimulus writes entries and wr_ptr, the monitor owns rd_ptr.
    logic [63:0] pkt_mem [0:1023];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    logic [63:0] sb[$];
    int          cyc       = 0;
    int          last_rd   = -1;
    int          rd_cyc    = -1000;
    int          spacing   = 0;
    int          bit_idx   = 0;
    int          low_run   = 0;
    int          last_low  = 0;
    int          pkts_done = 0;
    int          activity  = 0;
    logic        prev_ce   = 1'b0;
    logic [63:0] got       = 64'd0;
    logic [63:0] last_pkt  = 64'd0;
    logic [63:0] exp_pkt;

    sb_tx_serializer #(.PKT_W(PKT_W), .GAP_UI(GAP_UI)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_enable      (enable),
        .i_empty       (empty),
        .i_data        (data),
        .o_read_enable (rd),
        .o_txdata_sb   (txd),
        .o_clk_en      (clk_en),
        .o_busy        (busy),
        .o_pkt_done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [63:0] p);
        pkt_mem[wr_ptr % 1024] = p;
        wr_ptr++;
    endtask

    task automatic wait_done(input int maxc);
        int start;
        int k;
        start = pkts_done;
        for (k = 0; k < maxc && pkts_done == start; k++) @(negedge clk);
        chk("wait_done_timeout", (pkts_done != start), 1'b1);
    endtask

    task automatic wait_bits(input int n);
        int k;
        for (k = 0; k < 1000 && !(clk_en && bit_idx == n); k++) @(negedge clk);
        chk("wait_bits_timeout", (k < 1000), 1'b1);
    endtask

    // Monitor: samples 1 time unit after each rising edge, serves pops, scores packets.
    initial begin
        empty = 1'b1;
        data  = 64'd0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                chk("reset_outputs", {rd, txd, clk_en, busy, done}, 5'b0);
                sb.delete();
                bit_idx = 0;
                prev_ce = 1'b0;
                low_run = 0;
                last_rd = -1;
                rd_cyc  = -1000;
            end else begin
                chk("tx_quiet_outside_pkt", (!clk_en && txd), 1'b0);
                chk("busy_flag", ((clk_en || rd || done) && !busy), 1'b0);
                if (rd) begin
                    chk("pop_conditions", (enable && !empty), 1'b1);
                    if (last_rd >= 0) begin
                        spacing = cyc - last_rd;
                        chk("pop_spacing_min", (spacing >= SPACING), 1'b1);
                    end
                    last_rd = cyc;
                    rd_cyc  = cyc;
                    if (wr_ptr > rd_ptr) begin
                        data = pkt_mem[rd_ptr % 1024];
                        rd_ptr++;
                        sb.push_back(data);
                    end
                end
                if (clk_en) begin
                    if (!prev_ce) begin
                        chk("first_ui_latency", cyc - rd_cyc, 2);
                        last_low = low_run;
                        bit_idx  = 0;
                    end
                    if (bit_idx < 64) got[bit_idx] = txd;
                    chk("pkt_done_position", done, (bit_idx == PKT_W - 1));
                    if (done) begin
                        if (sb.size() == 0) begin
                            chk("scoreboard_underflow", 1'b1, 1'b0);
                        end else begin
                            exp_pkt = sb.pop_front();
                            chk("pkt_data", got, exp_pkt);
                        end
                        last_pkt = got;
                        pkts_done++;
                    end
                    bit_idx++;
                    low_run = 0;
                end else begin
                    chk("pkt_done_outside", done, 1'b0);
                    if (prev_ce) chk("clk_en_run_length", bit_idx, PKT_W);
                    low_run++;
                end
                if (rd || txd || clk_en || busy || done) activity++;
                prev_ce = clk_en;
            end
            empty = (wr_ptr == rd_ptr);
        end
    end

    // Stimulus: directed scenarios followed by a randomized traffic phase.
    initial begin
        int p0;
        int a0;
        int n_rand;
        logic [63:0] rp;

        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_state", {rd, txd, clk_en, busy, done}, 5'b0);

        // Single known packet.
        p0 = pkts_done;
        push(64'h0123_4567_89AB_CDEF);
        enable = 1'b1;
        wait_done(300);
        chk("t1_pkt", last_pkt, 64'h0123_4567_89AB_CDEF);
        repeat (40) @(negedge clk);
        chk("t1_count", pkts_done - p0, 1);
        chk("t1_idle", busy, 1'b0);

        // Two packets back-to-back.
        push(64'hFFFF_FFFF_FFFF_FFFF);
        push(64'h0000_0000_0000_0000);
        wait_done(300);
        chk("t2_pkt1", last_pkt, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_done(300);
        chk("t2_pkt2", last_pkt, 64'h0000_0000_0000_0000);
        chk("t2_spacing", spacing, SPACING);
        chk("t2_low_gap", last_low, LOW_RUN);
        repeat (40) @(negedge clk);

        // Empty FIFO: nothing may happen.
        a0 = activity;
        repeat (200) @(negedge clk);
        chk("t3_no_activity", activity - a0, 0);

        // Enable dropped mid-packet with a second packet pending.
        p0 = pkts_done;
        push(64'hDEAD_BEEF_CAFE_F00D);
        push(64'h1122_3344_5566_7788);
        wait_bits(11);
        enable = 1'b0;
        wait_done(300);
        repeat (150) @(negedge clk);
        chk("t4_completed", pkts_done - p0, 1);
        chk("t4_pkt", last_pkt, 64'hDEAD_BEEF_CAFE_F00D);
        chk("t4_no_second_pop", wr_ptr - rd_ptr, 1);
        chk("t4_idle", busy, 1'b0);
        enable = 1'b1;
        wait_done(300);
        chk("t4_pkt2", last_pkt, 64'h1122_3344_5566_7788);
        repeat (40) @(negedge clk);

        // Reset asserted mid-packet.
        push(64'hA5A5_5A5A_0F0F_F0F0);
        wait_bits(21);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_clk_en_abort", clk_en, 1'b0);
        chk("t5_txd_abort", txd, 1'b0);
        chk("t5_busy_abort", busy, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        a0 = activity;
        repeat (100) @(negedge clk);
        chk("t5_no_activity", activity - a0, 0);

        // FIFO becomes non-empty during the gap: fetch right after the gap ends.
        push(64'h8000_0000_0000_0001);
        wait_done(300);
        repeat (10) @(negedge clk);
        push(64'h7FFF_0000_FFFF_0000);
        wait_done(300);
        chk("t6_pkt", last_pkt, 64'h7FFF_0000_FFFF_0000);
        chk("t6_spacing", spacing, SPACING);
        repeat (40) @(negedge clk);

        // Randomized traffic with random enable toggling.
        p0 = pkts_done;
        n_rand = 0;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) enable = ~enable;
            if ($urandom_range(0, 1) == 1) begin
                rp = {$urandom, $urandom};
                push(rp);
                n_rand++;
            end
            repeat ($urandom_range(1, 80)) @(negedge clk);
        end
        enable = 1'b1;
        for (int k = 0; k < 8000 && (wr_ptr != rd_ptr || busy); k++) @(negedge clk);
        chk("rand_drained", (wr_ptr == rd_ptr && !busy), 1'b1);
        chk("rand_count", pkts_done - p0, n_rand);
        chk("rand_scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
